// File: rtl/sio_niu_outbound_sched_if.sv
// sio_niu_outbound_sched_if: response-queue and NIU-boundary signals of the outbound scheduler.
interface sio_niu_outbound_sched_if #(parameter int CNT_W = 4);
    logic             dma_rsp_vld;
    logic [127:0]     dma_rsp_hdr;
    logic             dma_rsp_hdr_pop;
    logic [127:0]     dma_rsp_data;
    logic             dma_rsp_data_pop;
    logic             wack_vld;
    logic [127:0]     wack_hdr;
    logic             wack_pop;
    logic             niu_sio_credit;
    logic             sio_niu_hdr_vld;
    logic             sio_niu_datareq;
    logic [127:0]     sio_niu_data;
    logic [7:0]       sio_niu_parity;
    logic [CNT_W-1:0] credit_avail;
    logic             credit_err;

    modport slave (
        input  dma_rsp_vld, dma_rsp_hdr, dma_rsp_data, wack_vld, wack_hdr, niu_sio_credit,
        output dma_rsp_hdr_pop, dma_rsp_data_pop, wack_pop, sio_niu_hdr_vld, sio_niu_datareq,
               sio_niu_data, sio_niu_parity, credit_avail, credit_err
    );

    modport master (
        output dma_rsp_vld, dma_rsp_hdr, dma_rsp_data, wack_vld, wack_hdr, niu_sio_credit,
        input  dma_rsp_hdr_pop, dma_rsp_data_pop, wack_pop, sio_niu_hdr_vld, sio_niu_datareq,
               sio_niu_data, sio_niu_parity, credit_avail, credit_err
    );
endinterface

// File: rtl/sio_niu_outbound_sched.sv
// sio_niu_outbound_sched: round-robin DMA-response / write-ack scheduler onto the NIU outbound bus,
// with packet credits, header + 4-beat payload sequencing and per-lane even parity.
module sio_niu_outbound_sched #(
    parameter int CREDITS = 8,
    parameter int CNT_W   = 4
) (
    input logic                     iol2clk,
    input logic                     rst_l,
    sio_niu_outbound_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PAY0, PAY1, PAY2, PAY3} state_t;

    state_t           state_q, state_d;
    logic             last_dma_q;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic             err_q, err_d;
    logic             hdr_vld_q, datareq_q;
    logic [127:0]     data_q, data_d;
    logic [7:0]       parity_q, parity_d;
    logic             busy, can_gnt, gnt_dma, gnt_wack, gnt, ret, full;

    always_comb begin
        busy     = state_q != IDLE;
        // Pops stay low while reset is held, even though they are combinational.
        can_gnt  = rst_l && !busy && credit_q != '0;
        gnt_dma  = can_gnt && bus.dma_rsp_vld && (!bus.wack_vld || !last_dma_q);
        gnt_wack = can_gnt && bus.wack_vld && !gnt_dma;
        gnt      = gnt_dma || gnt_wack;
        ret      = bus.niu_sio_credit;
        full     = credit_q == CNT_W'(CREDITS);
        credit_d = (gnt && !ret) ? credit_q - CNT_W'(1) :
                   (!gnt && ret && !full) ? credit_q + CNT_W'(1) : credit_q;
        err_d    = err_q || (!gnt && ret && full);
        state_d  = gnt_dma ? PAY0 : (!busy || state_q == PAY3) ? IDLE : state_t'(state_q + 3'd1);
        data_d   = gnt_dma ? bus.dma_rsp_hdr : gnt_wack ? bus.wack_hdr : busy ? bus.dma_rsp_data : '0;
        for (int i = 0; i < 8; i++) parity_d[i] = ^data_d[16*i +: 16];
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            last_dma_q <= 1'b0;
            credit_q   <= CNT_W'(CREDITS);
            err_q      <= 1'b0;
            hdr_vld_q  <= 1'b0;
            datareq_q  <= 1'b0;
            data_q     <= '0;
            parity_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_dma_q <= gnt ? gnt_dma : last_dma_q;
            credit_q   <= credit_d;
            err_q      <= err_d;
            hdr_vld_q  <= gnt;
            datareq_q  <= gnt_dma;
            data_q     <= data_d;
            parity_q   <= parity_d;
        end
    end

    assign bus.dma_rsp_hdr_pop  = gnt_dma;
    assign bus.wack_pop         = gnt_wack;
    assign bus.dma_rsp_data_pop = busy;
    assign bus.sio_niu_hdr_vld  = hdr_vld_q;
    assign bus.sio_niu_datareq  = datareq_q;
    assign bus.sio_niu_data     = data_q;
    assign bus.sio_niu_parity   = parity_q;
    assign bus.credit_avail     = credit_q;
    assign bus.credit_err       = err_q;
endmodule

// File: tb/tb_sio_niu_outbound_sched.sv
// tb_sio_niu_outbound_sched: directed scenarios plus random traffic against a packet-level model.
module tb_sio_niu_outbound_sched;
    localparam int CREDITS = 8;

    logic iol2clk;
    logic rst_l;
    int   n_assert = 0;
    int   n_fail   = 0;

    sio_niu_outbound_sched_if #(.CNT_W(4)) bus();

    sio_niu_outbound_sched #(.CREDITS(CREDITS), .CNT_W(4)) dut (
        .iol2clk(iol2clk),
        .rst_l  (rst_l),
        .bus    (bus)
    );

    initial begin
        iol2clk = 1'b0;
        forever #5 iol2clk = ~iol2clk;
    end

    // Packet-level model: remaining payload beats, credit pool, last winner.
    int           m_beats;
    int           m_credits;
    logic         m_err;
    logic         m_last_dma;
    int           m_gkind;
    logic         e_hdr_vld, e_datareq;
    logic [127:0] e_data;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] lane_par(logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_beats = 0; m_credits = CREDITS; m_err = 1'b0; m_last_dma = 1'b0; m_gkind = 0;
    endtask

    // Called at posedge+1 with inputs already driven; checks pops, then the registered result.
    task automatic cyc();
        logic busy, wd, ww, g;
        #1;
        busy = m_beats > 0;
        wd = 1'b0; ww = 1'b0;
        if (!busy && m_credits > 0) begin
            if (bus.dma_rsp_vld && bus.wack_vld) begin wd = !m_last_dma; ww = m_last_dma; end
            else begin wd = bus.dma_rsp_vld; ww = bus.wack_vld; end
        end
        g = wd || ww;
        chk("hdr_pop", bus.dma_rsp_hdr_pop, wd);
        chk("wack_pop", bus.wack_pop, ww);
        chk("data_pop", bus.dma_rsp_data_pop, busy);
        chk("credit_avail", bus.credit_avail, m_credits);
        chk("credit_err", bus.credit_err, m_err);
        e_hdr_vld = g;
        e_datareq = wd;
        e_data    = wd ? bus.dma_rsp_hdr : ww ? bus.wack_hdr : busy ? bus.dma_rsp_data : '0;
        if (g && !bus.niu_sio_credit) m_credits--;
        else if (!g && bus.niu_sio_credit) begin
            if (m_credits == CREDITS) m_err = 1'b1;
            else m_credits++;
        end
        m_beats = wd ? 4 : busy ? m_beats - 1 : 0;
        if (g) m_last_dma = wd;
        m_gkind = wd ? 1 : ww ? 2 : 0;
        @(posedge iol2clk);
        #1;
        chk("hdr_vld", bus.sio_niu_hdr_vld, e_hdr_vld);
        chk("datareq", bus.sio_niu_datareq, e_datareq);
        chk("data", bus.sio_niu_data, e_data);
        chk("parity", bus.sio_niu_parity, lane_par(e_data));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        rst_l = 1'b0;
        #1;
        model_reset();
        chk("rst_hdr_vld", bus.sio_niu_hdr_vld, 0);
        chk("rst_datareq", bus.sio_niu_datareq, 0);
        chk("rst_data", bus.sio_niu_data, 0);
        chk("rst_parity", bus.sio_niu_parity, 0);
        chk("rst_credit", bus.credit_avail, CREDITS);
        chk("rst_err", bus.credit_err, 0);
        chk("rst_hdr_pop", bus.dma_rsp_hdr_pop, 0);
        chk("rst_wack_pop", bus.wack_pop, 0);
        chk("rst_data_pop", bus.dma_rsp_data_pop, 0);
        @(posedge iol2clk);
        #1;
        rst_l = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.dma_rsp_vld = 1'b0; bus.wack_vld = 1'b0; bus.niu_sio_credit = 1'b0;
        bus.dma_rsp_hdr = '0; bus.wack_hdr = '0; bus.dma_rsp_data = '0;
    endtask

    initial begin
        rst_l = 1'b1;
        idle_inputs();
        bus.dma_rsp_vld = 1'b1;
        bus.wack_vld    = 1'b1;
        #2;
        @(posedge iol2clk);
        #1;
        do_reset();
        idle_inputs();

        // Single DMA response: header then four payload beats.
        bus.dma_rsp_vld = 1'b1;
        bus.dma_rsp_hdr = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        cyc();
        bus.dma_rsp_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.dma_rsp_data = rnd128();
            cyc();
        end
        bus.dma_rsp_data = '0;
        cyc();
        chk("dma_credit7", bus.credit_avail, 7);

        // Three back-to-back write acks.
        do_reset();
        bus.wack_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.wack_hdr = rnd128();
            cyc();
        end
        bus.wack_vld = 1'b0;
        cyc();
        chk("wack_credit5", bus.credit_avail, 5);

        // Both sources held: alternation until the credit pool is empty.
        do_reset();
        bus.dma_rsp_vld = 1'b1;
        bus.wack_vld    = 1'b1;
        for (int k = 0; k < 24; k++) begin
            bus.dma_rsp_hdr  = rnd128();
            bus.wack_hdr     = rnd128();
            bus.dma_rsp_data = rnd128();
            cyc();
            if (k == 0) chk("first_grant_dma", m_gkind, 1);
            if (k == 5) chk("sixth_cycle_wack", m_gkind, 2);
        end
        chk("drained_credit0", bus.credit_avail, 0);

        // Starved: wack held, nothing granted until one credit comes back.
        bus.dma_rsp_vld = 1'b0;
        bus.dma_rsp_data = '0;
        for (int k = 0; k < 3; k++) cyc();
        bus.niu_sio_credit = 1'b1;
        cyc();
        chk("no_unblock_same_cycle", m_gkind, 0);
        bus.niu_sio_credit = 1'b0;
        cyc();
        chk("grant_after_return", m_gkind, 2);
        cyc();
        chk("blocked_again", m_gkind, 0);
        chk("blocked_credit0", bus.credit_avail, 0);

        // Over-return is sticky; simultaneous grant and return is a no-op on the count.
        do_reset();
        idle_inputs();
        bus.niu_sio_credit = 1'b1;
        cyc();
        bus.niu_sio_credit = 1'b0;
        chk("overflow_err", bus.credit_err, 1);
        chk("overflow_credit8", bus.credit_avail, 8);
        bus.wack_vld = 1'b1;
        bus.wack_hdr = rnd128();
        bus.niu_sio_credit = 1'b1;
        cyc();
        idle_inputs();
        chk("gnt_ret_credit8", bus.credit_avail, 8);
        for (int k = 0; k < 3; k++) cyc();
        chk("err_sticky", bus.credit_err, 1);

        // Reset during PAY1 abandons the packet.
        do_reset();
        bus.dma_rsp_vld = 1'b1;
        bus.dma_rsp_hdr = rnd128();
        cyc();
        bus.dma_rsp_vld = 1'b0;
        bus.dma_rsp_data = rnd128();
        cyc();
        do_reset();
        bus.dma_rsp_vld = 1'b1;
        bus.dma_rsp_hdr = rnd128();
        bus.dma_rsp_data = rnd128();
        cyc();
        chk("fresh_header", m_gkind, 1);
        bus.dma_rsp_vld = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.dma_rsp_data = rnd128();
            cyc();
        end

        // Random traffic; ungranted requests are held until popped.
        do_reset();
        idle_inputs();
        for (int k = 0; k < 400; k++) begin
            if (!bus.dma_rsp_vld || m_gkind == 1) begin
                bus.dma_rsp_vld = 1'($urandom_range(0, 1));
                bus.dma_rsp_hdr = rnd128();
            end
            if (!bus.wack_vld || m_gkind == 2) begin
                bus.wack_vld = 1'($urandom_range(0, 1));
                bus.wack_hdr = rnd128();
            end
            bus.dma_rsp_data   = rnd128();
            bus.niu_sio_credit = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sio_niu_outbound_sched.md
Name: sio_niu_outbound_sched

Overview:
Sequences the SIU-to-NIU outbound interface (sio_niu_hdr_vld / sio_niu_datareq / sio_niu_data / sio_niu_parity). It arbitrates between two sources: DMA read responses, which carry a header plus 64 bytes of payload, and write acknowledges, which are header only. It enforces NIU packet credits, produces the header cycle followed by the 4-beat payload, and generates per-lane parity. It sits in SIO between the response queues and the NIU boundary, on iol2clk.

Parameters:
CREDITS, 8, initial and maximum NIU packet credits
CNT_W, 4, credit counter width (must hold CREDITS)

Ports:
iol2clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
dma_rsp_vld  in  1  DMA response header available
dma_rsp_hdr  in  128  DMA response header
dma_rsp_hdr_pop  out  1  header consumed this cycle
dma_rsp_data  in  128  current payload beat
dma_rsp_data_pop  out  1  payload beat consumed this cycle
wack_vld  in  1  write-ack header available
wack_hdr  in  128  write-ack header
wack_pop  out  1  write-ack consumed this cycle
niu_sio_credit  in  1  one-cycle pulse; NIU returns one packet credit
sio_niu_hdr_vld  out  1  header cycle
sio_niu_datareq  out  1  header is followed by 4 payload beats
sio_niu_data  out  128  header or payload
sio_niu_parity  out  8  lane parity of sio_niu_data
credit_avail  out  CNT_W  current credit count
credit_err  out  1  sticky; credit returned while counter already full

Behaviour:
- Reset (async, rst_l=0):
  - State returns to IDLE and the round-robin pointer favours DMA.
  - credit_avail=CREDITS, credit_err=0.
  - All sio_niu_* outputs are 0 and all pops are 0.
  - Any packet in progress is abandoned; it is neither resumed nor replayed.
- All sio_niu_* outputs are registered. Pops are combinational from current state and inputs.
- Arbitration happens only in IDLE and only when credit_avail>0.
  - One valid source: that source wins.
  - Both valid: the source not granted last wins; the pointer updates on every grant.
  - A credit returning in the same cycle does not unblock a grant when credit_avail==0.
- Grant in cycle c:
  - The winner's pop is asserted in cycle c.
  - At c+1: sio_niu_hdr_vld=1 and sio_niu_data=header.
  - sio_niu_datareq=1 at c+1 for a DMA grant, 0 for a write-ack grant.
- States:
  - IDLE.
  - PAY0..PAY3, entered only after a DMA grant.
  - IDLE -> PAY0 on DMA grant.
  - PAYn -> PAYn+1, and PAY3 -> IDLE, unconditionally each cycle.
  - In each PAYn, dma_rsp_data_pop=1 and dma_rsp_data is registered to sio_niu_data at the next edge, so payload beats appear at c+2..c+5 with hdr_vld=0 and datareq=0.
  - The source must present valid dma_rsp_data in every PAY cycle; no stall exists.
- Throughput:
  - Next arbitration after a DMA grant is c+5, so the next header appears at c+6 with no idle gap.
  - A write-ack grant leaves the block in IDLE, so acks can be issued every cycle.
- Idle cycles: hdr_vld=0, datareq=0, data=0, parity=0.
- Parity: sio_niu_parity[i] = XOR of sio_niu_data[16i+15:16i] (even parity), valid on every output cycle including payload beats.
- Credits:
  - Decrement by 1 on each grant; increment by 1 on each niu_sio_credit.
  - Grant and return in the same cycle leave the count unchanged.
  - A return at count==CREDITS with no grant saturates the count and sets credit_err, which stays set until reset.
- Valid inputs that are not granted are held by the source; the block only samples them in IDLE.

Test Plan:
- Reset then a single DMA response with dma_rsp_hdr=H and payload D0..D3 -> pop at c; hdr_vld=1 and datareq=1 with data=H at c+1; data=D0..D3 at c+2..c+5; credit_avail 8->7; parity matches per-lane XOR each cycle.
- wack_vld held for 3 cycles with no credit returns -> 3 consecutive hdr_vld cycles with datareq=0; credit_avail ends at 5.
- dma_rsp_vld and wack_vld both held continuously -> grants alternate DMA, WACK, DMA, ... starting with DMA; each DMA header is followed by exactly 4 payload beats and the ack header lands the cycle after beat 3.
- Credits drained to 0 with wack_vld held -> no pop and no hdr_vld; a niu_sio_credit pulse gives a grant on the following cycle, then the block blocks again.
- niu_sio_credit pulsed at credit_avail=8 -> count stays 8 and credit_err=1 until reset; a grant and a return in the same cycle leave the count unchanged.
- rst_l asserted in PAY1 -> outputs 0 immediately; credit_avail=8; the next grant starts a fresh header, with no leftover payload beats.
